// File: rtl/if_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response buffer and jump/stall handling.
// Responses to requests made before a jump are counted off by a drop counter instead of being flushed on the bus.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc;
  logic          run;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] aq_wr;
  logic [PW-1:0] aq_rd;
  logic [31:0]   aq_mem   [DEPTH];
  logic [31:0]   buf_addr [DEPTH];
  logic [31:0]   buf_data [DEPTH];

  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          issue;
  logic          rsp_take;
  logic          push;
  logic          pop;

  // Handshake: a request transfers on any rising edge where req_valid_o && req_ready_i;
  // the bus returns exactly one rsp_valid_i pulse per transferred request, in order.
  assign in_use      = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok   = in_use < {1'b0, DEPTH_C};
  assign req_valid_o = run && credit_ok && (hold_flag_i == 3'd0) && !jump_flag_i;
  assign req_addr_o  = pc;
  assign issue       = req_valid_o && req_ready_i;

  assign rsp_take = rsp_valid_i && (outstanding != '0);
  assign push     = rsp_take && (drop == '0) && !jump_flag_i;
  assign pop      = (count != '0) && (hold_flag_i < 3'd2) && !jump_flag_i;

  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? buf_data[rd_ptr] : 32'h0000_0001;
  assign inst_addr_o  = inst_valid_o ? buf_addr[rd_ptr] : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      run         <= 1'b0;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
    end else begin
      run <= 1'b1;
      if (issue)    aq_wr <= aq_wr + 1'b1;
      if (rsp_take) aq_rd <= aq_rd + 1'b1;
      if (issue && !rsp_take)      outstanding <= outstanding + 1'b1;
      else if (!issue && rsp_take) outstanding <= outstanding - 1'b1;

      // Everything still in flight after this edge belongs to the old stream.
      if (jump_flag_i) begin
        pc     <= jump_addr_i;
        drop   <= outstanding - {{(CW-1){1'b0}}, rsp_take};
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue) pc <= pc + 32'd4;
        if (rsp_take && (drop != '0)) drop <= drop - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) aq_mem[aq_wr] <= pc;
    if (push) begin
      buf_addr[wr_ptr] <= aq_mem[aq_rd];
      buf_data[wr_ptr] <= rsp_data_i;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a latency-programmable bus model answers requests, a monitor
// compares every consumed instruction against a queue of hand-listed fetch addresses.
module tb_if_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_q[$];
  logic [31:0] bus_q[$];
  int          due_q[$];
  logic [31:0] mon_e;

  // clock / reset
  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout actual=%0d_left required=0_left", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // bus model: accept sampled mid-cycle, answer in order after lat cycles
  always @(negedge clk) begin
    if (rst && req_valid_o && req_ready_i) begin
      bus_q.push_back(req_addr_o);
      due_q.push_back(cyc + lat);
    end
  end

  initial begin
    rsp_valid_i = 1'b0;
    rsp_data_i  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        bus_q.delete();
        due_q.delete();
        rsp_valid_i = 1'b0;
      end else if (bus_q.size() != 0 && due_q[0] <= cyc) begin
        rsp_valid_i = 1'b1;
        rsp_data_i  = mem_word(bus_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        rsp_valid_i = 1'b0;
      end
    end
  end

  // scoreboard monitor: an instruction is consumed on an edge with hold < 2 and no jump
  always @(negedge clk) begin
    if (rst && inst_valid_o && hold_flag_i < 3'd2 && !jump_flag_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra actual=%h required=none", inst_addr_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_addr", inst_addr_o, mon_e);
        check("stream_data", inst_o, mem_word(mon_e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    hold_flag_i = 3'd0; req_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", req_valid_o, 0);
    check("rst_req_addr", req_addr_o, 32'h0);
    check("rst_inst_valid", inst_valid_o, 0);
    check("rst_inst", inst_o, 32'h1);
    check("rst_inst_addr", inst_addr_o, 32'h0);

    // back-to-back stream from reset, 1-cycle bus
    push_run(32'h0, 8);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("first_req_valid", req_valid_o, 1);
    check("first_req_addr", req_addr_o, 32'h0);
    check("first_inst_valid", inst_valid_o, 0);
    @(negedge clk);
    check("second_req_addr", req_addr_o, 32'h4);
    @(negedge clk);
    check("third_req_addr", req_addr_o, 32'h8);
    check("c0_inst_addr", inst_addr_o, 32'h0);
    check("c0_inst_valid", inst_valid_o, 1);
    @(negedge clk);
    check("c1_inst_addr", inst_addr_o, 32'h4);
    @(negedge clk);
    check("c2_inst_addr", inst_addr_o, 32'h8);
    wait_empty("run0", 40);
    hold_flag_i = 3'd2;

    // Hold_If: no issue, no pop, head stays put
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_inst_addr", inst_addr_o, 32'h20);
      check("hold_inst_valid", inst_valid_o, 1);
      check("hold_req_valid", req_valid_o, 0);
    end
    push_run(32'h20, 8);
    @(posedge clk); #1; hold_flag_i = 3'd0;
    wait_empty("resume", 40);
    hold_flag_i = 3'd2;

    // jump with two responses in flight, then ready low for 3 cycles
    @(posedge clk); #1; rst = 1'b0; lat = 3; hold_flag_i = 3'd0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; jump_flag_i = 1'b1; jump_addr_i = 32'h100;
    push_run(32'h100, 8);
    @(negedge clk);
    check("jump_req_valid", req_valid_o, 0);
    @(posedge clk); #1; jump_flag_i = 1'b0; req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_valid", req_valid_o, 1);
      check("stall_req_addr", req_addr_o, 32'h100);
      check("drop_inst_valid", inst_valid_o, 0);
    end
    @(posedge clk); #1; req_ready_i = 1'b1;
    @(negedge clk);
    check("ready_req_addr", req_addr_o, 32'h100);
    check("drop_inst_valid", inst_valid_o, 0);
    @(negedge clk);
    check("next_req_addr", req_addr_o, 32'h104);
    check("next_req_valid", req_valid_o, 1);
    check("drop_inst_valid", inst_valid_o, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drop_inst_valid", inst_valid_o, 0);
    end
    @(negedge clk);
    check("jump_inst_addr", inst_addr_o, 32'h100);
    check("jump_inst_valid", inst_valid_o, 1);
    wait_empty("jump_run", 100);
    hold_flag_i = 3'd3;

    // fill the buffer under Hold_Id, then drain with Hold_Pc and resume
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("full_inst_addr", inst_addr_o, 32'h120);
    check("full_inst_valid", inst_valid_o, 1);
    check("full_req_valid", req_valid_o, 0);
    push_run(32'h120, 8);
    lat = 1;
    @(posedge clk); #1; hold_flag_i = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("holdpc_req_valid", req_valid_o, 0);
    end
    @(posedge clk); #1; hold_flag_i = 3'd0;
    wait_empty("full_drain", 60);
    hold_flag_i = 3'd2;

    // asynchronous reset between edges
    @(negedge clk);
    check("pre_rst_inst_valid", inst_valid_o, 1);
    check("pre_rst_inst_addr", inst_addr_o, 32'h140);
    #2 rst = 1'b0;
    #1;
    check("arst_req_valid", req_valid_o, 0);
    check("arst_req_addr", req_addr_o, 32'h0);
    check("arst_inst_valid", inst_valid_o, 0);
    check("arst_inst", inst_o, 32'h1);
    check("arst_inst_addr", inst_addr_o, 32'h0);
    push_run(32'h0, 4);
    hold_flag_i = 3'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    wait_empty("restart", 40);
    hold_flag_i = 3'd2;

    // jump overriding hold, pc wraps past the top of the address space
    repeat (2) @(posedge clk);
    #1; jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8;
    push_run(32'hFFFF_FFF8, 4);
    @(posedge clk); #1; jump_flag_i = 1'b0; hold_flag_i = 3'd0;
    wait_empty("wrap", 40);
    hold_flag_i = 3'd2;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, prefetch buffer entries (power of two, 2..4).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 jump_flag_i  input  1  redirect request from execute.
REQ-006 jump_addr_i  input  32  redirect target, word-aligned.
REQ-007 hold_flag_i  input  3  pipeline stall code: 0 none, 1 Hold_Pc, 2 Hold_If, 3 Hold_Id.
REQ-008 req_valid_o  output  1  fetch request valid to instruction bus.
REQ-009 req_addr_o  output  32  fetch address.
REQ-010 req_ready_i  input  1  bus accepts request this cycle.
REQ-011 rsp_valid_i  input  1  read data returned (in order, one per accepted request).
REQ-012 rsp_data_i  input  32  returned instruction word.
REQ-013 inst_o  output  32  instruction presented to if_id stage.
REQ-014 inst_addr_o  output  32  address of inst_o.
REQ-015 inst_valid_o  output  1  inst_o/inst_addr_o hold a real fetched instruction.

Function
REQ-016 pc register holds next address to request; req_addr_o SHALL equal pc.
REQ-017 Request accepted (issue) when req_valid_o && req_ready_i; pc SHALL advance by 4 on issue.
REQ-018 Credit rule: req_valid_o SHALL be 1 only when outstanding + buffer count < DEPTH, hold_flag_i < 1, and jump_flag_i == 0.
REQ-019 outstanding counter: +1 on issue, -1 on rsp_valid_i, both same cycle -> unchanged; never exceeds DEPTH.
REQ-020 Response with drop counter 0 SHALL push {pc_of_request, rsp_data_i} into buffer; request addresses tracked in an in-order address queue of DEPTH entries.
REQ-021 Pop condition: buffer non-empty and hold_flag_i < 2; pop occurs on that edge.
REQ-022 Output: buffer non-empty -> inst_o/inst_addr_o = head entry, inst_valid_o = 1; empty -> inst_o = 32'h0000_0001 (NOP), inst_addr_o = 0, inst_valid_o = 0.
REQ-023 Bypass: response arriving while buffer empty SHALL be visible on outputs the cycle after arrival (one-cycle latency rsp -> inst_o), no combinational rsp -> inst_o path.
REQ-024 Simultaneous push and pop with buffer full SHALL be permitted (count unchanged, no overflow).
REQ-025 Jump: when jump_flag_i = 1, on that edge pc <= jump_addr_i, buffer emptied, drop counter <= outstanding minus any response consumed that cycle; jump overrides hold and pop.
REQ-026 Responses while drop counter > 0 SHALL be discarded and decrement drop counter; no push.
REQ-027 Requests at the new target SHALL not issue until the cycle after jump_flag_i falls; responses after drop counter reaches 0 belong to the new stream.
REQ-028 Hold_Pc (1): no new issue; outstanding responses still pushed; pops continue.
REQ-029 Hold_If/Hold_Id (>=2): no issue, no pop; outputs stable; pushes continue until full by credit.
REQ-030 pc wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

Reset
REQ-031 While rst = 0: pc = RESET_PC, buffer empty, outstanding = 0, drop = 0, req_valid_o = 0, inst_o = 32'h0000_0001, inst_addr_o = 0, inst_valid_o = 0.
REQ-032 First request SHALL be asserted the first edge after rst rises; reset mid-transaction discards all in-flight responses (bus assumed reset together).

Verification
REQ-033 Reset release, ready=1, 1-cycle response -> addresses 0x0,0x4,0x8 issued back-to-back; inst_addr_o 0x0,0x4,0x8 on consecutive cycles, inst_valid_o = 1.
REQ-034 hold_flag_i = 2 for 5 cycles, ready=1 -> at most DEPTH requests outstanding+buffered, inst_o unchanged, no loss; resumes in order after release.
REQ-035 Jump to 0x100 with 2 responses outstanding -> both discarded, next inst_addr_o = 0x100, inst_valid_o low between.
REQ-036 req_ready_i = 0 for 3 cycles -> req_valid_o/req_addr_o held stable, pc unchanged.
REQ-037 Full buffer with simultaneous push+pop -> count stays DEPTH, order preserved.
REQ-038 Async rst asserted mid-fetch (no clock edge) -> outputs immediately at REQ-031 values.
